ov7670_dvp_tx: RTL and testbench

Synthesizable OV7670-style DVP sensor emulator. It generates VSYNC/HREF framing and a YUV 4:2:2 byte stream carrying test patterns. It is the transmit end of the camera pixel interface and drives the capture path (sync register stage, capture decoder, SDRAM write FIFO) in place of the real sensor for bring-up and loopback. Output is one byte per iCLK cycle, in the OV7670 default byte order.

---
 rtl/ov7670_tx_pkg.sv | 34 +++
 rtl/ov7670_pattern_gen.sv | 35 +++
 rtl/ov7670_dvp_tx.sv | 184 ++++++++++++++++++
 tb/tb_ov7670_dvp_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_tx_pkg.sv
// Shared types and constants for the OV7670-style DVP transmitter: FSM states,
// pattern codes and the YCbCr colour-bar table.
package ov7670_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBP,
    ACTIVE,
    VFP
  } state_t;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_FLAT  = 2'd3;

  localparam logic [7:0] Y_BLACK   = 8'd16;
  localparam logic [7:0] Y_WHITE   = 8'd235;
  localparam logic [7:0] C_NEUTRAL = 8'd128;

  // {Y, Cb, Cr} per bar; index 0 is the leftmost bar
  localparam logic [0:7][23:0] BAR_YCBCR = {
    24'hEB_80_80,  // white
    24'hD2_10_92,  // yellow
    24'hAA_A6_10,  // cyan
    24'h91_36_22,  // green
    24'h6A_CA_DE,  // magenta
    24'h51_5A_F0,  // red
    24'h29_F0_6E,  // blue
    24'h10_80_80   // black
  };

endpackage

// File: rtl/ov7670_pattern_gen.sv
// Combinational test-pattern byte generator; the result feeds the registered
// pixel byte output of ov7670_dvp_tx. Byte phase 0..3 = Cb, Y0, Cr, Y1.
module ov7670_pattern_gen
  import ov7670_tx_pkg::*;
(
  input  logic [7:0] x,
  input  logic       check_cell,
  input  logic [1:0] phase,
  input  logic [1:0] pattern,
  input  logic [2:0] bar,
  input  logic [2:0] chroma_bar,
  input  logic [7:0] frame_y,
  output logic [7:0] data
);

  logic [7:0] luma;
  logic [7:0] chroma;

  always_comb begin
    luma   = frame_y;
    chroma = C_NEUTRAL;
    case (pattern)
      PAT_BARS: begin
        luma   = BAR_YCBCR[bar][23:16];
        // chroma always belongs to the even pixel of the pair
        chroma = phase[1] ? BAR_YCBCR[chroma_bar][7:0] : BAR_YCBCR[chroma_bar][15:8];
      end
      PAT_RAMP:  luma = x;
      PAT_CHECK: luma = check_cell ? Y_WHITE : Y_BLACK;
      default:   luma = frame_y;
    endcase
    data = phase[0] ? luma : chroma;
  end

endmodule

// File: rtl/ov7670_dvp_tx.sv
// OV7670-style DVP sensor emulator: VSYNC/HREF framing plus a YUV 4:2:2 byte stream.
// Define OV7670_TX_PCLK_OUT_EN to add oPCLK and hold each byte for two iCLK cycles.
module ov7670_dvp_tx
  import ov7670_tx_pkg::*;
#(
  parameter int H_ACT       = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACT       = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BP        = 17,
  parameter int V_FP        = 10,
  parameter int CHECK_SHIFT = 5
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iRUN,
  input  logic [1:0]  iPATTERN,
  output logic        oVSYNC,
  output logic        oHREF,
  output logic [7:0]  oDATA,
  output logic        oFRAME_DONE,
  output logic [15:0] oFRAME_CNT,
  output logic        oBUSY
`ifdef OV7670_TX_PCLK_OUT_EN
  ,
  output logic        oPCLK
`endif
);

  localparam int L     = 2 * H_ACT + H_BLANK;
  localparam int BW    = $clog2(L);
  localparam int BAR_W = H_ACT / 8;
  localparam int BPW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int PW    = (CHECK_SHIFT > 7) ? CHECK_SHIFT + 1 : 8;
  localparam logic [BW-1:0]  BYTE_LAST = BW'(L - 1);
  localparam logic [BW-1:0]  ACT_BYTES = BW'(2 * H_ACT);
  localparam logic [BPW-1:0] BAR_LAST  = BPW'(BAR_W - 1);

  state_t         state, n_state;
  logic [BW-1:0]  byte_cnt, n_byte;
  logic [9:0]     line_cnt, n_line;
  logic [2:0]     bar_idx, n_bar, chroma_bar, n_cbar;
  logic [BPW-1:0] bar_pix, n_bpix;
  logic [1:0]     pattern_q;
  logic [7:0]     frame_y;
  logic           start, last_n, href_n, en;
  logic [PW-1:0]  pix_x;
  logic [1:0]     gen_pattern;
  logic [7:0]     gen_frame;
  logic [7:0]     gen_byte;

  // Next non-empty phase after s; IDLE means the frame has ended.
  function automatic state_t next_phase(state_t s);
    if (s == IDLE && VSYNC_LINES > 0) return VSYNC;
    if ((s == IDLE || s == VSYNC) && V_BP > 0) return VBP;
    if ((s == IDLE || s == VSYNC || s == VBP) && V_ACT > 0) return ACTIVE;
    if (s != VFP && V_FP > 0) return VFP;
    return IDLE;
  endfunction

  function automatic logic [9:0] last_line(state_t s);
    case (s)
      VSYNC:   return 10'(VSYNC_LINES - 1);
      VBP:     return 10'(V_BP - 1);
      ACTIVE:  return 10'(V_ACT - 1);
      VFP:     return 10'(V_FP - 1);
      default: return 10'd0;
    endcase
  endfunction

  // Next-cycle position; outputs are registered from these so they move with the state.
  always_comb begin
    n_state = state;
    n_byte  = byte_cnt;
    n_line  = line_cnt;
    start   = 1'b0;
    if (state == IDLE) begin
      if (iRUN) begin
        n_state = next_phase(IDLE);
        start   = 1'b1;
      end
    end else if (byte_cnt == BYTE_LAST) begin
      n_byte = '0;
      if (line_cnt == last_line(state)) begin
        n_line  = '0;
        n_state = next_phase(state);
        if (n_state == IDLE && iRUN) begin
          n_state = next_phase(IDLE);
          start   = 1'b1;
        end
      end else begin
        n_line = line_cnt + 10'd1;
      end
    end else begin
      n_byte = byte_cnt + BW'(1);
    end

    n_bar  = bar_idx;
    n_bpix = bar_pix;
    n_cbar = chroma_bar;
    if (n_byte == '0) begin
      n_bar  = '0;
      n_bpix = '0;
      n_cbar = '0;
    end else if (!n_byte[0]) begin
      if (bar_pix == BAR_LAST) begin
        n_bpix = '0;
        n_bar  = bar_idx + 3'd1;
      end else begin
        n_bpix = bar_pix + BPW'(1);
      end
      if (!n_byte[1]) n_cbar = n_bar;
    end

    last_n = (n_state != IDLE) && (n_byte == BYTE_LAST) &&
             (n_line == last_line(n_state)) && (next_phase(n_state) == IDLE);
    href_n = (n_state == ACTIVE) && (n_byte < ACT_BYTES);
  end

  assign pix_x       = PW'(n_byte >> 1);
  assign gen_pattern = start ? iPATTERN : pattern_q;
  assign gen_frame   = start ? oFRAME_CNT[7:0] : frame_y;

  ov7670_pattern_gen u_pattern_gen (
    .x          (pix_x[7:0]),
    .check_cell (pix_x[CHECK_SHIFT] ^ n_line[CHECK_SHIFT]),
    .phase      (n_byte[1:0]),
    .pattern    (gen_pattern),
    .bar        (n_bar),
    .chroma_bar (n_cbar),
    .frame_y    (gen_frame),
    .data       (gen_byte)
  );

`ifdef OV7670_TX_PCLK_OUT_EN
  // Advance on the cycle where oPCLK falls so data is stable across its rising edge.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) oPCLK <= 1'b0;
    else         oPCLK <= ~oPCLK;
  end
  assign en = oPCLK;
`else
  assign en = 1'b1;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      line_cnt    <= '0;
      bar_idx     <= '0;
      bar_pix     <= '0;
      chroma_bar  <= '0;
      pattern_q   <= '0;
      frame_y     <= '0;
      oVSYNC      <= 1'b0;
      oHREF       <= 1'b0;
      oDATA       <= 8'h00;
      oFRAME_DONE <= 1'b0;
      oFRAME_CNT  <= 16'd0;
      oBUSY       <= 1'b0;
    end else begin
      oFRAME_DONE <= en && last_n;
      if (en) begin
        state      <= n_state;
        byte_cnt   <= n_byte;
        line_cnt   <= n_line;
        bar_idx    <= n_bar;
        bar_pix    <= n_bpix;
        chroma_bar <= n_cbar;
        if (start) begin
          pattern_q <= iPATTERN;
          frame_y   <= oFRAME_CNT[7:0];
        end
        if (last_n) oFRAME_CNT <= oFRAME_CNT + 16'd1;
        oVSYNC <= (n_state == VSYNC);
        oHREF  <= href_n;
        oDATA  <= href_n ? gen_byte : 8'h00;
        oBUSY  <= (n_state != IDLE);
      end
    end
  end

endmodule

// File: tb/tb_ov7670_dvp_tx.sv
// Directed bench for ov7670_dvp_tx with a 20-cycle line and 140-cycle frame;
// the oPCLK variant is exercised when OV7670_TX_PCLK_OUT_EN is defined.
module tb_ov7670_dvp_tx;

  // clock / reset
  logic iclk = 1'b0;
  always #5 iclk = ~iclk;

  logic        rst_n = 1'b0;
  logic        run   = 1'b0;
  logic [1:0]  pat   = 2'd0;
  logic        vsync, href, frame_done, busy;
  logic [7:0]  data;
  logic [15:0] frame_cnt;
`ifdef OV7670_TX_PCLK_OUT_EN
  logic        pclk;
`endif

  ov7670_dvp_tx #(
    .H_ACT(8), .H_BLANK(4), .V_ACT(4), .VSYNC_LINES(1), .V_BP(1), .V_FP(1), .CHECK_SHIFT(1)
  ) dut (
    .iCLK        (iclk),
    .iRST_N      (rst_n),
    .iRUN        (run),
    .iPATTERN    (pat),
    .oVSYNC      (vsync),
    .oHREF       (href),
    .oDATA       (data),
    .oFRAME_DONE (frame_done),
    .oFRAME_CNT  (frame_cnt),
    .oBUSY       (busy)
`ifdef OV7670_TX_PCLK_OUT_EN
    ,
    .oPCLK       (pclk)
`endif
  );

  // hand-computed active lines, first byte in the top bits
  localparam logic [127:0] LINE_BARS  = 128'h80EB80D2_A6AA1091_CA6ADE51_F0296E10;
  localparam logic [127:0] LINE_RAMP  = 128'h80008001_80028003_80048005_80068007;
  localparam logic [127:0] LINE_FLAT2 = 128'h80028002_80028002_80028002_80028002;
  localparam logic [127:0] LINE_CHK_A = 128'h8010801080EB80EB8010801080EB80EB;
  localparam logic [127:0] LINE_CHK_B = 128'h80EB80EB8010801080EB80EB80108010;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]  dt [420];
  logic        vs [420];
  logic        hr [420];
  logic        dn [420];
  logic        bz [420];
  logic        pk [420];
  logic [15:0] ct [420];
  int vs_n, hr_n, dn_n, bz_n, blank_bad;

  // scoreboard check
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver / monitor tasks
  task automatic sample(input int i);
    dt[i] = data; vs[i] = vsync; hr[i] = href; dn[i] = frame_done;
    bz[i] = busy; ct[i] = frame_cnt;
`ifdef OV7670_TX_PCLK_OUT_EN
    pk[i] = pclk;
`else
    pk[i] = 1'b0;
`endif
  endtask

  task automatic capture(input int first, input int n, input int chg_at,
                         input logic nrun, input logic [1:0] npat);
    for (int i = first; i < n; i++) begin
      @(negedge iclk);
      sample(i);
      if (i == chg_at) begin
        run = nrun;
        pat = npat;
      end
    end
  endtask

  task automatic stats(input int n);
    vs_n = 0; hr_n = 0; dn_n = 0; bz_n = 0; blank_bad = 0;
    for (int i = 0; i < n; i++) begin
      vs_n += int'(vs[i]);
      hr_n += int'(hr[i]);
      dn_n += int'(dn[i]);
      bz_n += int'(bz[i]);
      if (!hr[i] && dt[i] != 8'h00) blank_bad++;
    end
  endtask

  function automatic logic [127:0] line_at(input int base);
    logic [127:0] r = '0;
    for (int b = 0; b < 16; b++) r = {r[119:0], dt[base + b]};
    return r;
  endfunction

  initial begin
    repeat (3) @(negedge iclk);
    check("reset_outputs", {vsync, href, data, frame_done, frame_cnt, busy}, '0);

`ifdef OV7670_TX_PCLK_OUT_EN
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge iclk);
      sample(i);
    end
    begin
      int no_toggle = 0;
      for (int i = 1; i < 8; i++) if (pk[i] === pk[i-1]) no_toggle++;
      check("pclk_period2", no_toggle, 0);
    end
    run = 1'b1;
    pat = 2'd0;
    for (int k = 0; k < 6 && !vsync; k++) @(negedge iclk);
    check("pclk_vsync_start", vsync, 1'b1);
    sample(0);
    capture(1, 280, 100, 1'b0, 2'd0);
    stats(280);
    check("pclk_vsync_len", vs_n, 40);
    check("pclk_href_len", hr_n, 128);
    check("pclk_done_count", dn_n, 1);
    check("pclk_done_pos", dn[278], 1'b1);
    check("pclk_first_bytes", {dt[80], dt[81], dt[82], dt[83], dt[84], dt[85], dt[86], dt[87]},
          64'h8080EBEB8080D2D2);
    begin
      int bad_edge = 0;
      for (int i = 1; i < 280; i++)
        if (dt[i] !== dt[i-1] && !(pk[i-1] === 1'b1 && pk[i] === 1'b0)) bad_edge++;
      check("pclk_data_on_fall", bad_edge, 0);
    end
    capture(0, 4, -1, 1'b0, 2'd0);
    check("pclk_idle_cnt", {bz[3], ct[3]}, {1'b0, 16'd1});
`else
    // frame A: colour bars, pattern for B set just before its VSYNC entry
    rst_n = 1'b1;
    run   = 1'b1;
    pat   = 2'd0;
    capture(0, 140, 139, 1'b1, 2'd1);
    stats(140);
    check("a_vsync_first", vs[0], 1'b1);
    check("a_vsync_len", vs_n, 20);
    check("a_href_len", hr_n, 64);
    check("a_blank_data", blank_bad, 0);
    check("a_first_bytes", {dt[40], dt[41], dt[42], dt[43]}, 32'h80EB80D2);
    check("a_bars_line0", line_at(40), LINE_BARS);
    check("a_bars_line3", line_at(100), LINE_BARS);
    check("a_done_count", dn_n, 1);
    check("a_done_last", dn[139], 1'b1);

    // frame B: ramp
    capture(0, 140, 139, 1'b1, 2'd3);
    stats(140);
    check("b_cnt_after_a", ct[0], 16'd1);
    check("b_ramp_line0", line_at(40), LINE_RAMP);
    check("b_ramp_line3", line_at(100), LINE_RAMP);
    check("b_blank_bytes", {hr[56], dt[56], dt[57], dt[58], dt[59]}, 33'd0);
    check("b_blank_data", blank_bad, 0);

    // frame C: flat Y = 2, iRUN dropped during active line 2
    capture(0, 140, 85, 1'b0, 2'd3);
    stats(140);
    check("c_flat_line0", line_at(40), LINE_FLAT2);
    check("c_flat_line3", line_at(100), LINE_FLAT2);
    check("c_vsync_len", vs_n, 20);
    check("c_busy_all", bz_n, 140);
    check("c_done_count", dn_n, 1);
    check("c_done_last", dn[139], 1'b1);
    capture(0, 10, -1, 1'b0, 2'd3);
    stats(10);
    check("c_idle_busy", bz_n, 0);
    check("c_idle_vsync", vs_n, 0);
    check("c_idle_cnt", ct[9], 16'd3);

    // frames D, E, F back to back, pattern 0 -> 2 during D
    run = 1'b1;
    pat = 2'd0;
    capture(0, 140, 60, 1'b1, 2'd2);
    stats(140);
    check("d_bars_line3", line_at(100), LINE_BARS);
    check("d_done_pos", {dn_n[7:0], dn[139]}, {8'd1, 1'b1});
    capture(0, 140, -1, 1'b1, 2'd2);
    stats(140);
    check("e_vsync_first", vs[0], 1'b1);
    check("e_chk_line0", line_at(40), LINE_CHK_A);
    check("e_chk_line2", line_at(80), LINE_CHK_B);
    check("e_done_pos", {dn_n[7:0], dn[139]}, {8'd1, 1'b1});
    capture(0, 140, 50, 1'b0, 2'd2);
    stats(140);
    check("f_chk_line1", line_at(60), LINE_CHK_A);
    check("f_chk_line3", line_at(100), LINE_CHK_B);
    check("f_done_pos", {dn_n[7:0], dn[139]}, {8'd1, 1'b1});
    capture(0, 5, -1, 1'b0, 2'd2);
    check("f_cnt_after", ct[4], 16'd6);

    // asynchronous reset in the middle of an active line
    run = 1'b1;
    pat = 2'd1;
    repeat (45) @(negedge iclk);
    check("rst_pre_href", href, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("rst_async_outputs", {vsync, href, data, frame_done, frame_cnt, busy}, '0);
    @(negedge iclk);
    rst_n = 1'b1;
    capture(0, 140, 100, 1'b0, 2'd1);
    stats(140);
    check("g_vsync_first", {vs[0], ct[0]}, {1'b1, 16'd0});
    check("g_ramp_line0", line_at(40), LINE_RAMP);
    check("g_done_pos", {dn_n[7:0], dn[139]}, {8'd1, 1'b1});
    capture(0, 3, -1, 1'b0, 2'd1);
    check("g_cnt_after", {bz[2], ct[2]}, {1'b0, 16'd1});
`endif

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
